// File: rtl/radar_signal_generator.sv
// -----------------------------------------------------------------------------
// radar_signal_generator
//
// Synthetic radar timing source. Produces ARP (azimuth reference), ACP
// (azimuth count) and TRIG (transmit trigger) pulse trains, all timed from a
// free-running asynchronous microsecond clock. Configuration is captured at the
// start of every revolution, so it can be retuned while the generator runs
// without tearing a pulse train.
//
// Ports
//   SYS_CLK         system clock; every register in the block uses it
//   RST             synchronous reset, active-high
//   US_CLK          asynchronous microsecond clock, one tick per rising edge
//   ENABLE          level; start and keep running
//   ACP_PER_ARP     ACP pulses per revolution (>= 1)
//   ACP_PERIOD_US   us ticks between ACP rising edges (>= 2)
//   TRIG_PER_ACP    triggers per ACP period (>= 1)
//   TRIG_PERIOD_US  us ticks between TRIG rising edges (>= 2)
//   PULSE_US        requested high time of every pulse, in us ticks
//   ARP/ACP/TRIG    registered pulse outputs
//   ACP_IDX         index of the current ACP within the revolution
//   TRIG_IDX        index of the most recently fired trigger within the ACP
//   RUNNING         high while in RUN or DRAIN
//   CFG_ERR         sticky: invalid configuration seen at a latch point
//   TRIG_CLIP       sticky: triggers dropped because they overran the ACP
// -----------------------------------------------------------------------------
module radar_signal_generator #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  SYS_CLK,
  input  logic                  RST,
  input  logic                  US_CLK,
  input  logic                  ENABLE,
  input  logic [DATA_WIDTH-1:0] ACP_PER_ARP,
  input  logic [DATA_WIDTH-1:0] ACP_PERIOD_US,
  input  logic [DATA_WIDTH-1:0] TRIG_PER_ACP,
  input  logic [DATA_WIDTH-1:0] TRIG_PERIOD_US,
  input  logic [DATA_WIDTH-1:0] PULSE_US,
  output logic                  ARP,
  output logic                  ACP,
  output logic                  TRIG,
  output logic [DATA_WIDTH-1:0] ACP_IDX,
  output logic [DATA_WIDTH-1:0] TRIG_IDX,
  output logic                  RUNNING,
  output logic                  CFG_ERR,
  output logic                  TRIG_CLIP
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] TWO = DATA_WIDTH'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // US_CLK synchronizer and registered rising-edge detector
  // ---------------------------------------------------------------------------
  logic sync_1, sync_2, sync_3;
  logic us_tick;

  always_ff @(posedge SYS_CLK) begin
    // NOTE: non-blocking (<=) for every flop, so all registers see the values
    // from before the edge and the synchronizer chain shifts by one stage.
    if (RST) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      sync_3  <= 1'b0;
      us_tick <= 1'b0;
    end else begin
      sync_1  <= US_CLK;
      sync_2  <= sync_1;
      sync_3  <= sync_2;
      us_tick <= sync_2 & ~sync_3;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                state_q, state_d;
  // Position of the most recently processed tick within the revolution.
  logic [DATA_WIDTH-1:0] us_in_acp_q, us_in_acp_d;
  logic [DATA_WIDTH-1:0] acp_idx_q, acp_idx_d;
  // Configuration captured at the start of the running revolution.
  logic [DATA_WIDTH-1:0] cfg_apa_q, cfg_apa_d;
  logic [DATA_WIDTH-1:0] cfg_ap_q, cfg_ap_d;
  logic [DATA_WIDTH-1:0] cfg_tpa_q, cfg_tpa_d;
  logic [DATA_WIDTH-1:0] cfg_tp_q, cfg_tp_d;
  logic [DATA_WIDTH-1:0] cfg_pulse_q, cfg_pulse_d;
  // Trigger schedule inside the current ACP: due time and index of the next
  // trigger, and a flag once no further trigger fits.
  logic [DATA_WIDTH-1:0] next_trig_q, next_trig_d;
  logic [DATA_WIDTH-1:0] trig_k_q, trig_k_d;
  logic                  trig_done_q, trig_done_d;
  logic [DATA_WIDTH-1:0] trig_idx_q, trig_idx_d;
  // Remaining high ticks after the current one, per output.
  logic [DATA_WIDTH-1:0] arp_cnt_q, arp_cnt_d;
  logic [DATA_WIDTH-1:0] acp_cnt_q, acp_cnt_d;
  logic [DATA_WIDTH-1:0] trig_cnt_q, trig_cnt_d;
  logic                  arp_q, arp_d;
  logic                  acp_q, acp_d;
  logic                  trig_q, trig_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  trig_clip_q, trig_clip_d;

  // ---------------------------------------------------------------------------
  // Per-tick working signals
  // ---------------------------------------------------------------------------
  logic                  rev_start, acp_start;
  logic [DATA_WIDTH-1:0] pos_us, pos_acp;
  logic [DATA_WIDTH-1:0] eff_apa, eff_ap, eff_tpa, eff_tp, eff_pulse;
  logic                  cfg_valid;
  logic [DATA_WIDTH-1:0] min_per, width_cap, width;
  logic                  arp_ev, trig_ev;
  logic [DATA_WIDTH-1:0] trig_base, trig_fire_k, trig_k_next;
  logic [DATA_WIDTH:0]   trig_sum_w;
  logic                  trig_more, trig_nofit;
  logic                  do_fire, do_latch, do_idle;

  // One output's next {level, remaining-count}; an event reloads the counter.
  function automatic logic [DATA_WIDTH:0] pulse_step(
    input logic                  ev,
    input logic [DATA_WIDTH-1:0] cnt,
    input logic [DATA_WIDTH-1:0] w
  );
    logic [DATA_WIDTH-1:0] nxt;
    if (ev)              nxt = w - ONE;
    else if (cnt != '0)  nxt = cnt - ONE;
    else                 nxt = '0;
    return {ev || (cnt != '0), nxt};
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    state_d     = state_q;
    us_in_acp_d = us_in_acp_q;
    acp_idx_d   = acp_idx_q;
    cfg_apa_d   = cfg_apa_q;
    cfg_ap_d    = cfg_ap_q;
    cfg_tpa_d   = cfg_tpa_q;
    cfg_tp_d    = cfg_tp_q;
    cfg_pulse_d = cfg_pulse_q;
    next_trig_d = next_trig_q;
    trig_k_d    = trig_k_q;
    trig_done_d = trig_done_q;
    trig_idx_d  = trig_idx_q;
    arp_cnt_d   = arp_cnt_q;
    acp_cnt_d   = acp_cnt_q;
    trig_cnt_d  = trig_cnt_q;
    arp_d       = arp_q;
    acp_d       = acp_q;
    trig_d      = trig_q;
    cfg_err_d   = cfg_err_q;
    trig_clip_d = trig_clip_q;
    do_fire     = 1'b0;
    do_latch    = 1'b0;
    do_idle     = 1'b0;

    // Position of the tick being processed. From IDLE it is always us 0.
    if (state_q == IDLE) begin
      pos_us    = '0;
      pos_acp   = '0;
      rev_start = 1'b1;
    end else if (us_in_acp_q == cfg_ap_q - ONE) begin
      pos_us = '0;
      if (acp_idx_q == cfg_apa_q - ONE) begin
        pos_acp   = '0;
        rev_start = 1'b1;
      end else begin
        pos_acp   = acp_idx_q + ONE;
        rev_start = 1'b0;
      end
    end else begin
      pos_us    = us_in_acp_q + ONE;
      pos_acp   = acp_idx_q;
      rev_start = 1'b0;
    end
    acp_start = (pos_us == '0);

    // A revolution start is the latch point, so it already runs on the live
    // configuration; every other tick uses the captured copy.
    eff_apa   = rev_start ? ACP_PER_ARP    : cfg_apa_q;
    eff_ap    = rev_start ? ACP_PERIOD_US  : cfg_ap_q;
    eff_tpa   = rev_start ? TRIG_PER_ACP   : cfg_tpa_q;
    eff_tp    = rev_start ? TRIG_PERIOD_US : cfg_tp_q;
    eff_pulse = rev_start ? PULSE_US       : cfg_pulse_q;
    cfg_valid = (eff_apa != '0) && (eff_ap >= TWO) &&
                (eff_tpa != '0) && (eff_tp >= TWO);

    // Width clamp leaves at least one low tick before the next rising edge.
    min_per   = (eff_tp < eff_ap) ? eff_tp : eff_ap;
    width_cap = min_per - ONE;
    width     = (eff_pulse < width_cap) ? eff_pulse : width_cap;
    if (width == '0) width = ONE;

    arp_ev = acp_start && (pos_acp == '0);

    // Trigger 0 always fits at the ACP start; later ones come from the
    // running accumulator.
    if (acp_start) begin
      trig_ev     = 1'b1;
      trig_base   = '0;
      trig_fire_k = '0;
    end else begin
      trig_ev     = !trig_done_q && (pos_us == next_trig_q);
      trig_base   = next_trig_q;
      trig_fire_k = trig_k_q;
    end
    trig_sum_w  = {1'b0, trig_base} + {1'b0, eff_tp};
    trig_k_next = trig_fire_k + ONE;
    trig_more   = trig_k_next < eff_tpa;
    trig_nofit  = trig_sum_w[DATA_WIDTH] || (trig_sum_w[DATA_WIDTH-1:0] >= eff_ap);

    if (us_tick) begin
      case (state_q)
        IDLE: begin
          if (ENABLE) begin
            if (cfg_valid) begin
              state_d  = RUN;
              do_latch = 1'b1;
              do_fire  = 1'b1;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        default: begin
          if (rev_start) begin
            // A new revolution only begins if still enabled; a drain (or a
            // disable landing exactly on the wrap) ends here without an ARP.
            if ((state_q == RUN) && ENABLE) begin
              if (cfg_valid) begin
                do_latch = 1'b1;
                do_fire  = 1'b1;
              end else begin
                cfg_err_d = 1'b1;
                do_idle   = 1'b1;
              end
            end else begin
              do_idle = 1'b1;
            end
          end else begin
            state_d = ENABLE ? RUN : DRAIN;
            do_fire = 1'b1;
          end
        end
      endcase
    end

    if (do_latch) begin
      cfg_apa_d   = ACP_PER_ARP;
      cfg_ap_d    = ACP_PERIOD_US;
      cfg_tpa_d   = TRIG_PER_ACP;
      cfg_tp_d    = TRIG_PERIOD_US;
      cfg_pulse_d = PULSE_US;
    end

    if (do_fire) begin
      us_in_acp_d = pos_us;
      acp_idx_d   = pos_acp;
      {arp_d, arp_cnt_d}   = pulse_step(arp_ev, arp_cnt_q, width);
      {acp_d, acp_cnt_d}   = pulse_step(acp_start, acp_cnt_q, width);
      {trig_d, trig_cnt_d} = pulse_step(trig_ev, trig_cnt_q, width);
      if (trig_ev) begin
        trig_idx_d  = trig_fire_k;
        next_trig_d = trig_sum_w[DATA_WIDTH-1:0];
        trig_k_d    = trig_k_next;
        trig_done_d = !trig_more || trig_nofit;
        if (trig_more && trig_nofit) trig_clip_d = 1'b1;
      end
    end

    if (do_idle) begin
      state_d     = IDLE;
      us_in_acp_d = '0;
      acp_idx_d   = '0;
      next_trig_d = '0;
      trig_k_d    = '0;
      trig_done_d = 1'b0;
      trig_idx_d  = '0;
      arp_cnt_d   = '0;
      acp_cnt_d   = '0;
      trig_cnt_d  = '0;
      arp_d       = 1'b0;
      acp_d       = 1'b0;
      trig_d      = 1'b0;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      us_in_acp_q <= '0;
      acp_idx_q   <= '0;
      cfg_apa_q   <= '0;
      cfg_ap_q    <= '0;
      cfg_tpa_q   <= '0;
      cfg_tp_q    <= '0;
      cfg_pulse_q <= '0;
      next_trig_q <= '0;
      trig_k_q    <= '0;
      trig_done_q <= 1'b0;
      trig_idx_q  <= '0;
      arp_cnt_q   <= '0;
      acp_cnt_q   <= '0;
      trig_cnt_q  <= '0;
      arp_q       <= 1'b0;
      acp_q       <= 1'b0;
      trig_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      trig_clip_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      us_in_acp_q <= us_in_acp_d;
      acp_idx_q   <= acp_idx_d;
      cfg_apa_q   <= cfg_apa_d;
      cfg_ap_q    <= cfg_ap_d;
      cfg_tpa_q   <= cfg_tpa_d;
      cfg_tp_q    <= cfg_tp_d;
      cfg_pulse_q <= cfg_pulse_d;
      next_trig_q <= next_trig_d;
      trig_k_q    <= trig_k_d;
      trig_done_q <= trig_done_d;
      trig_idx_q  <= trig_idx_d;
      arp_cnt_q   <= arp_cnt_d;
      acp_cnt_q   <= acp_cnt_d;
      trig_cnt_q  <= trig_cnt_d;
      arp_q       <= arp_d;
      acp_q       <= acp_d;
      trig_q      <= trig_d;
      cfg_err_q   <= cfg_err_d;
      trig_clip_q <= trig_clip_d;
    end
  end

  assign ARP       = arp_q;
  assign ACP       = acp_q;
  assign TRIG      = trig_q;
  assign ACP_IDX   = acp_idx_q;
  assign TRIG_IDX  = trig_idx_q;
  assign RUNNING   = (state_q != IDLE);
  assign CFG_ERR   = cfg_err_q;
  assign TRIG_CLIP = trig_clip_q;

endmodule

// File: tb/tb_radar_signal_generator.sv
// -----------------------------------------------------------------------------
// tb_radar_signal_generator
//
// Drives US_CLK one microsecond at a time (8 SYS_CLK cycles each). For every
// tick a behavioural model predicts the outputs, the prediction is queued, and
// it is compared four SYS_CLK cycles after the US_CLK edge. One cycle earlier
// the outputs must still hold the previous prediction.
// -----------------------------------------------------------------------------
module tb_radar_signal_generator;

  logic        SYS_CLK;
  logic        RST;
  logic        US_CLK;
  logic        ENABLE;
  logic [31:0] acp_per_arp, acp_period_us, trig_per_acp, trig_period_us, pulse_us;
  logic        ARP, ACP, TRIG, RUNNING, CFG_ERR, TRIG_CLIP;
  logic [31:0] ACP_IDX, TRIG_IDX;

  radar_signal_generator #(.DATA_WIDTH(32)) dut (
    .SYS_CLK        (SYS_CLK),
    .RST            (RST),
    .US_CLK         (US_CLK),
    .ENABLE         (ENABLE),
    .ACP_PER_ARP    (acp_per_arp),
    .ACP_PERIOD_US  (acp_period_us),
    .TRIG_PER_ACP   (trig_per_acp),
    .TRIG_PERIOD_US (trig_period_us),
    .PULSE_US       (pulse_us),
    .ARP            (ARP),
    .ACP            (ACP),
    .TRIG           (TRIG),
    .ACP_IDX        (ACP_IDX),
    .TRIG_IDX       (TRIG_IDX),
    .RUNNING        (RUNNING),
    .CFG_ERR        (CFG_ERR),
    .TRIG_CLIP      (TRIG_CLIP)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  typedef struct {
    bit     arp, acp, trig, running;
    int     acp_idx, trig_idx;
    longint us;
  } exp_t;

  exp_t sb_q[$];
  exp_t prev_exp;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: revolution position as a plain us offset, pulses as
  // "high while fewer than w ticks have passed since the rising event".
  // ---------------------------------------------------------------------------
  int     m_state;             // 0 idle, 1 run, 2 drain
  int     m_rev;
  int     m_apa, m_ap, m_tpa, m_tp, m_w;
  longint m_now;
  longint last_arp, last_acp, last_trig;
  int     w_arp, w_acp, w_trig;
  int     m_acp_idx, m_trig_idx;
  bit     m_cfg_err, m_clip;

  task automatic model_idle();
    m_state    = 0;
    m_rev      = 0;
    m_acp_idx  = 0;
    m_trig_idx = 0;
    last_arp   = -1000;
    last_acp   = -1000;
    last_trig  = -1000;
  endtask

  task automatic model_reset();
    model_idle();
    m_cfg_err = 0;
    m_clip    = 0;
    prev_exp  = '{arp: 0, acp: 0, trig: 0, running: 0, acp_idx: 0, trig_idx: 0, us: m_now};
  endtask

  task automatic model_fire(input int r);
    int u;
    m_rev     = r;
    u         = r % m_ap;
    m_acp_idx = r / m_ap;
    if (r == 0) begin last_arp = m_now; w_arp = m_w; end
    if (u == 0) begin last_acp = m_now; w_acp = m_w; end
    if ((u % m_tp == 0) && (u / m_tp < m_tpa)) begin
      last_trig  = m_now;
      w_trig     = m_w;
      m_trig_idx = u / m_tp;
    end
  endtask

  task automatic model_step(output exp_t e);
    int r;
    bit rs;
    int cap;
    m_now++;
    rs = 0;
    if (m_state == 0) begin
      r  = 0;
      rs = 1;
    end else begin
      r = m_rev + 1;
      if (r == m_apa * m_ap) begin r = 0; rs = 1; end
    end
    if (rs) begin
      if ((m_state != 2) && ENABLE) begin
        if (acp_per_arp >= 1 && acp_period_us >= 2 && trig_per_acp >= 1 && trig_period_us >= 2) begin
          m_apa = int'(acp_per_arp);
          m_ap  = int'(acp_period_us);
          m_tpa = int'(trig_per_acp);
          m_tp  = int'(trig_period_us);
          cap   = ((m_tp < m_ap) ? m_tp : m_ap) - 1;
          m_w   = (int'(pulse_us) < cap) ? int'(pulse_us) : cap;
          if (m_w < 1) m_w = 1;
          if (longint'(m_tpa - 1) * m_tp >= m_ap) m_clip = 1;
          m_state = 1;
          model_fire(r);
        end else begin
          m_cfg_err = 1;
          model_idle();
        end
      end else if (m_state != 0) begin
        model_idle();
      end
    end else begin
      m_state = ENABLE ? 1 : 2;
      model_fire(r);
    end
    e.arp      = (m_now - last_arp)  < w_arp;
    e.acp      = (m_now - last_acp)  < w_acp;
    e.trig     = (m_now - last_trig) < w_trig;
    e.running  = (m_state != 0);
    e.acp_idx  = m_acp_idx;
    e.trig_idx = m_trig_idx;
    e.us       = m_now;
  endtask

  task automatic cmp_exp(input string when, input exp_t e);
    check($sformatf("%s_arp@us%0d", when, e.us),      {31'b0, ARP},     {31'b0, e.arp});
    check($sformatf("%s_acp@us%0d", when, e.us),      {31'b0, ACP},     {31'b0, e.acp});
    check($sformatf("%s_trig@us%0d", when, e.us),     {31'b0, TRIG},    {31'b0, e.trig});
    check($sformatf("%s_running@us%0d", when, e.us),  {31'b0, RUNNING}, {31'b0, e.running});
    check($sformatf("%s_acp_idx@us%0d", when, e.us),  ACP_IDX,  32'(e.acp_idx));
    check($sformatf("%s_trig_idx@us%0d", when, e.us), TRIG_IDX, 32'(e.trig_idx));
  endtask

  task automatic do_us();
    exp_t e;
    @(negedge SYS_CLK);
    US_CLK = 1'b1;
    model_step(e);
    sb_q.push_back(e);
    repeat (3) @(posedge SYS_CLK);
    #1;
    cmp_exp("hold", prev_exp);
    @(posedge SYS_CLK);
    #1;
    e = sb_q.pop_front();
    cmp_exp("tick", e);
    prev_exp = e;
    @(negedge SYS_CLK);
    US_CLK = 1'b0;
    repeat (3) @(negedge SYS_CLK);
  endtask

  task automatic run_us(input int n);
    for (int i = 0; i < n; i++) do_us();
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_cfg_err"},   {31'b0, CFG_ERR},   {31'b0, m_cfg_err});
    check({tag, "_trig_clip"}, {31'b0, TRIG_CLIP}, {31'b0, m_clip});
  endtask

  // Reset asserted for one edge must clear every output on the next cycle.
  task automatic apply_reset(input string tag);
    @(negedge SYS_CLK);
    RST = 1'b1;
    @(posedge SYS_CLK);
    #1;
    check({tag, "_arp"},       {31'b0, ARP},       32'd0);
    check({tag, "_acp"},       {31'b0, ACP},       32'd0);
    check({tag, "_trig"},      {31'b0, TRIG},      32'd0);
    check({tag, "_running"},   {31'b0, RUNNING},   32'd0);
    check({tag, "_acp_idx"},   ACP_IDX,            32'd0);
    check({tag, "_trig_idx"},  TRIG_IDX,           32'd0);
    check({tag, "_cfg_err"},   {31'b0, CFG_ERR},   32'd0);
    check({tag, "_trig_clip"}, {31'b0, TRIG_CLIP}, 32'd0);
    repeat (2) @(negedge SYS_CLK);
    RST = 1'b0;
    model_reset();
  endtask

  initial begin
    RST            = 1'b1;
    US_CLK         = 1'b0;
    ENABLE         = 1'b0;
    acp_per_arp    = 32'd4;
    acp_period_us  = 32'd10;
    trig_per_acp   = 32'd3;
    trig_period_us = 32'd3;
    pulse_us       = 32'd1;
    m_now          = 0;
    m_apa = 4; m_ap = 10; m_tpa = 3; m_tp = 3; m_w = 1;
    w_arp = 1; w_acp = 1; w_trig = 1;
    model_reset();
    repeat (3) @(posedge SYS_CLK);
    apply_reset("reset");

    // Idle with ENABLE low: nothing may start.
    run_us(3);

    // Basic run: three full 40 us revolutions.
    ENABLE = 1'b1;
    run_us(120);
    check_flags("basic");

    // Stop at us 12: revolution completes, no ARP at us 40.
    run_us(12);
    ENABLE = 1'b0;
    run_us(30);

    // Retune ACP_PER_ARP 4 -> 6 at us 15: 40 us then 60 us revolutions.
    ENABLE = 1'b1;
    run_us(15);
    acp_per_arp = 32'd6;
    run_us(87);
    ENABLE = 1'b0;
    run_us(70);
    acp_per_arp = 32'd4;

    // Width clamp: PULSE_US=50 gives 2 us pulses, then PULSE_US=0 gives 1 us.
    pulse_us = 32'd50;
    ENABLE   = 1'b1;
    run_us(45);
    pulse_us = 32'd0;
    run_us(45);
    ENABLE = 1'b0;
    run_us(45);
    pulse_us = 32'd1;
    check_flags("width");

    // Clip: 5 triggers requested but only 0/3/6/9 fit.
    trig_per_acp = 32'd5;
    ENABLE       = 1'b1;
    run_us(45);
    check_flags("clip");
    ENABLE = 1'b0;
    run_us(45);
    trig_per_acp = 32'd3;

    // Invalid configuration: stays idle and flags CFG_ERR.
    acp_period_us = 32'd1;
    ENABLE        = 1'b1;
    run_us(5);
    check_flags("invalid");
    acp_period_us = 32'd10;

    // Reset while ARP is high, then a clean restart.
    pulse_us = 32'd5;
    run_us(41);
    check_flags("sticky");
    check("arp_before_reset", {31'b0, ARP}, 32'd1);
    apply_reset("midreset");
    run_us(5);
    check_flags("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/radar_signal_generator.md
# radar_signal_generator

Synthetic radar timing source producing ARP (azimuth reference), ACP (azimuth count) and TRIG (transmit trigger) pulse trains from a free-running microsecond tick. It is the transmit-side counterpart of the radar statistics block. Looping its outputs back into that block must reproduce the programmed revolution time, ACP count and trigger count. Configuration is sampled once per revolution, so software can retune the generator while it is running without producing torn pulse trains.

## Interface
Parameters:
- DATA_WIDTH, 32, width of all configuration inputs and index outputs.

Ports:
- SYS_CLK  in  1  system clock; every register in the block is clocked by it.
- RST  in  1  synchronous reset, active-high.
- US_CLK  in  1  asynchronous microsecond clock; each rising edge is one µs tick.
- ENABLE  in  1  level; start and keep running.
- ACP_PER_ARP  in  DATA_WIDTH  ACP pulses per revolution; must be ≥1.
- ACP_PERIOD_US  in  DATA_WIDTH  µs ticks between ACP rising edges; must be ≥2.
- TRIG_PER_ACP  in  DATA_WIDTH  triggers per ACP period; must be ≥1.
- TRIG_PERIOD_US  in  DATA_WIDTH  µs ticks between TRIG rising edges; must be ≥2.
- PULSE_US  in  DATA_WIDTH  high time of every pulse, in µs ticks.
- ARP, ACP, TRIG  out  1  registered pulse outputs.
- ACP_IDX  out  DATA_WIDTH  index of the current ACP within the revolution.
- TRIG_IDX  out  DATA_WIDTH  index of the last trigger within the current ACP.
- RUNNING  out  1  high in states RUN and DRAIN.
- CFG_ERR  out  1  sticky flag; invalid configuration seen at a latch point.
- TRIG_CLIP  out  1  sticky flag; triggers were dropped because they did not fit in an ACP period.

## Operation
- US_CLK goes through a 2-flop synchronizer and then a rising-edge detector. The result is us_tick, high for one SYS_CLK cycle per µs.
- FSM states: IDLE, RUN, DRAIN.
- IDLE → RUN on the first us_tick with ENABLE=1 and valid configuration.
  - That tick is revolution µs 0. ARP, ACP and TRIG all rise.
- RUN → DRAIN when ENABLE=0 at any us_tick.
- DRAIN → RUN if ENABLE returns to 1 before the end of the revolution.
- DRAIN → IDLE on the tick that would begin the next revolution. No ARP is emitted on that tick.
- Configuration latch point: IDLE→RUN, and every revolution wrap while in RUN.
  - Invalid configuration at a latch point: set CFG_ERR and go to IDLE, with all outputs low.
  - In IDLE, the block retries on every tick while ENABLE=1.
- Counters, advanced on us_tick in RUN or DRAIN:
  - us_in_acp counts 0..ACP_PERIOD_US-1. When it wraps, acp_idx increments.
  - acp_idx counts 0..ACP_PER_ARP-1. When it wraps, the revolution ends.
- Pulse events:
  - ACP rises when us_in_acp==0.
  - ARP rises when us_in_acp==0 and acp_idx==0.
  - Trigger k rises at us_in_acp==k·TRIG_PERIOD_US, for k<TRIG_PER_ACP and k·TRIG_PERIOD_US<ACP_PERIOD_US.
  - Triggers that fail the second condition are suppressed and set TRIG_CLIP.
- Pulse width:
  - Effective width is max(1, min(PULSE_US, min(TRIG_PERIOD_US, ACP_PERIOD_US)−1)).
  - Each output has its own down-counter, reloaded on its rising event.
  - This rule guarantees at least 1 µs of low time between pulses, so every edge is detectable.
- ACP_IDX = acp_idx. TRIG_IDX = index of the most recently fired trigger.
- Arithmetic: unsigned DATA_WIDTH arithmetic. The k·TRIG_PERIOD_US comparison uses a running accumulator (next_trig_us += TRIG_PERIOD_US), not a multiplier.
- An accumulator carry-out counts as "does not fit" (clip).
- CFG_ERR and TRIG_CLIP are cleared only by RST.

## Timing
- Reset values: all outputs are 0, the FSM is in IDLE, and all counters and synchronizer flops are 0.
- Latency from a US_CLK rising edge to an output change is 4 SYS_CLK cycles:
  - 2 synchronizer stages, 1 edge register, 1 output register.
- Simultaneous events on one tick: ARP, ACP and TRIG0 rise in the same SYS_CLK cycle. This matches the simultaneous-edge handling on the statistics side.
- RST asserted mid-pulse: all outputs are low on the next cycle and no partial pulse is stretched.
- Configuration writes between latch points have no effect until the next revolution.
- ENABLE deasserted mid-pulse in DRAIN: the pulse completes at its normal width.

## Test plan
- Basic run, with ACP_PER_ARP=4, ACP_PERIOD_US=10, TRIG_PER_ACP=3, TRIG_PERIOD_US=3, PULSE_US=1:
  - ARP every 40 µs, ACP every 10 µs, TRIG at µs 0/3/6 of each ACP.
  - Looped back into the statistics block: ARP_US=40, ACP_CNT=4, TRIG_CNT=3, and CALIBRATED=1 after the third ARP.
- Clip: TRIG_PER_ACP=5, TRIG_PERIOD_US=3, ACP_PERIOD_US=10 → TRIG at µs 0/3/6/9 only, TRIG_IDX max 3, TRIG_CLIP=1.
- Width clamp: PULSE_US=50 with TRIG_PERIOD_US=3 → every pulse is high for 2 µs and low for at least 1 µs. PULSE_US=0 → 1 µs pulses.
- Retune: ACP_PER_ARP changed 4→6 at µs 15 → the current revolution stays at 40 µs and the next one is 60 µs.
- Stop and invalid configuration:
  - ENABLE low at µs 12 → the revolution completes, there is no ARP at µs 40, and RUNNING falls at µs 40.
  - ACP_PERIOD_US=1 with ENABLE=1 → CFG_ERR=1, FSM stays in IDLE, outputs stay low.
- Reset mid-operation: RST during an ARP high → all outputs are 0 next cycle. A clean restart then gives ARP at the first tick with ENABLE=1.
